ea_calc: RTL and testbench
==========================

Name: ea_calc

Overview:
- Parametrised effective-address calculator; successor to the fixed 16-bit indexed-only address adder in the MSP430 execution path.
- Sits between the control unit, the register file (Sout/Dout) and the memory data bus.
- Computes indexed source and destination EAs (Rn + X) from extension words, and the @Rn+ post-increment value with byte/word step.
- Explicit start/abort, per-result valid strobes and a sequence-done pulse.

Parameters:
W, 16, datapath width of registers, extension words and results.
INC_BYTE, 1, @Rn+ increment when bw=1.
INC_WORD, 2, @Rn+ increment when bw=0.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
start  input  1  level: high requests and sustains a calculation (MC equivalent); low aborts.
AdAs  input  3  [2]=Ad, [1:0]=As of the current instruction; sampled at start.
bw  input  1  1=byte op, 0=word op; sampled at start.
Sout  input  W  source register value; sampled at start.
Dout  input  W  destination register value; sampled at start.
MDB_out  input  W  memory data bus, carries extension word.
mdb_valid  input  1  MDB_out holds the next extension word this cycle.
ea_out  output  W  computed effective address.
ea_valid  output  1  one-cycle strobe: ea_out updated this cycle.
ea_sel  output  1  0=ea_out is source EA, 1=destination EA; meaningful when ea_valid.
incr_out  output  W  post-incremented source register value for @Rn+.
incr_valid  output  1  one-cycle strobe: incr_out updated this cycle.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse at end of a completed sequence.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; ea_out, ea_sel, incr_out=0; ea_valid, incr_valid, busy, done=0. Reset overrides start and mdb_valid.
- States: IDLE, SRC, DST, INC, FIN.
- IDLE, start=1: latch Sout, Dout, AdAs, bw.
  - Next state: As=01 -> SRC; else As=11 -> INC; else Ad=1 -> DST; else FIN.
- SRC: wait for mdb_valid; on it, ea_out<=Sout_l+MDB_out, ea_sel<=0, ea_valid<=1.
  - Then Ad=1 -> DST, else FIN.
- INC: single cycle; incr_out<=Sout_l+(bw_l?INC_BYTE:INC_WORD), incr_valid<=1.
  - Then Ad=1 -> DST, else FIN.
- DST: wait for mdb_valid; on it, ea_out<=Dout_l+MDB_out, ea_sel<=1, ea_valid<=1; then FIN.
- mdb_valid on the transition edge into DST is not consumed: the destination word needs a distinct later mdb_valid.
- FIN: done<=1 for one cycle; then IDLE. done requires start held through FIN.
- Latency:
  - ea_valid rises the cycle after the consuming mdb_valid edge.
  - incr_valid rises 2 cycles after start is sampled.
  - Register/indirect modes with no calc (As=00/10, Ad=0): done 2 cycles after start.
- Arithmetic is unsigned modulo 2^W, no carry out; e.g. W=16: 0xFFFF+0x0002=0x0001.
- Hold rules:
  - ea_out and incr_out hold their last values between strobes, after abort, and across IDLE.
  - Strobes are 0 in all other cycles.
- Abort: start=0 at any edge outside IDLE -> IDLE next cycle, busy=0, no further strobes, no done.
  - A strobe already registered on that edge still appears.
- Ignored inputs:
  - start high while busy does not relatch inputs.
  - mdb_valid in IDLE, INC or FIN is ignored.
- busy is registered: 1 from the cycle after start is accepted until the cycle after FIN/abort.

Optional Feature:
EA_ALIGN_CHECK_EN
- Defined:
  - Adds output ea_misalign (1 bit, reset 0).
  - Asserted coincident with ea_valid when bw_l=0 and the new ea_out[0]=1.
  - Low otherwise; does not alter the sequence.
- Undefined: port absent; no alignment logic.

Test Plan:
- Source indexed: W=16, AdAs=001, Sout=0x0200, start, mdb_valid with MDB=0x0010 -> next cycle ea_out=0x0210, ea_sel=0, ea_valid=1; done one cycle later.
- Both indexed: AdAs=101, Sout=0x0100, Dout=0x0300, MDB 0x0004 then 0x0008 (two separate mdb_valid) -> ea_out=0x0104 (sel 0), then 0x0308 (sel 1), then done.
- Autoincrement + dest: AdAs=111, Sout=0xFFFF, bw=1 -> incr_out=0x0000 with incr_valid; then DST with MDB=0x0002, Dout=0x1000 -> ea_out=0x1002, sel=1.
- Word autoincrement: AdAs=011, bw=0, Sout=0x0400 -> incr_out=0x0402, no ea_valid, done.
- Abort: AdAs=101, drop start while in DST -> idle next cycle, no second ea_valid, no done, ea_out holds source EA; reset mid-SRC -> all outputs 0.
- EA_ALIGN_CHECK_EN: AdAs=001, bw=0, Sout=0x0201, MDB=0x0000 -> ea_out=0x0201, ea_misalign=1; same with bw=1 -> ea_misalign=0.

Source files
------------

// File: rtl/ea_calc_if.sv
// Handshake/bus bundle between the control unit, register file and ea_calc.
// The ea_misalign signal exists only when EA_ALIGN_CHECK_EN is defined.
interface ea_calc_if #(
  parameter int W = 16
);
  logic         start;
  logic [2:0]   AdAs;
  logic         bw;
  logic [W-1:0] Sout;
  logic [W-1:0] Dout;
  logic [W-1:0] MDB_out;
  logic         mdb_valid;
  logic [W-1:0] ea_out;
  logic         ea_valid;
  logic         ea_sel;
  logic [W-1:0] incr_out;
  logic         incr_valid;
  logic         busy;
  logic         done;
`ifdef EA_ALIGN_CHECK_EN
  logic         ea_misalign;

  modport master (
    output start, AdAs, bw, Sout, Dout, MDB_out, mdb_valid,
    input  ea_out, ea_valid, ea_sel, incr_out, incr_valid, busy, done, ea_misalign
  );

  modport slave (
    input  start, AdAs, bw, Sout, Dout, MDB_out, mdb_valid,
    output ea_out, ea_valid, ea_sel, incr_out, incr_valid, busy, done, ea_misalign
  );
`else
  modport master (
    output start, AdAs, bw, Sout, Dout, MDB_out, mdb_valid,
    input  ea_out, ea_valid, ea_sel, incr_out, incr_valid, busy, done
  );

  modport slave (
    input  start, AdAs, bw, Sout, Dout, MDB_out, mdb_valid,
    output ea_out, ea_valid, ea_sel, incr_out, incr_valid, busy, done
  );
`endif
endinterface

// File: rtl/ea_calc.sv
// Effective-address calculator: indexed source/destination EAs and @Rn+ increment.
// Optional EA_ALIGN_CHECK_EN adds ea_misalign for odd word-access EAs.
module ea_calc #(
  parameter int W        = 16,
  parameter int INC_BYTE = 1,
  parameter int INC_WORD = 2
) (
  input logic  clk,
  input logic  rst_n,
  ea_calc_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SRC,
    DST,
    INC,
    FIN
  } state_t;

  state_t       state;
  logic [W-1:0] sout_l;
  logic [W-1:0] dout_l;
  logic [1:0]   as_l;
  logic         ad_l;
  logic         bw_l;

  logic [W-1:0] src_sum;
  logic [W-1:0] dst_sum;
  logic [W-1:0] inc_sum;

  always_comb begin
    src_sum = sout_l + bus.MDB_out;
    dst_sum = dout_l + bus.MDB_out;
    inc_sum = sout_l + (bw_l ? W'(INC_BYTE) : W'(INC_WORD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sout_l         <= '0;
      dout_l         <= '0;
      as_l           <= '0;
      ad_l           <= 1'b0;
      bw_l           <= 1'b0;
      bus.ea_out     <= '0;
      bus.ea_sel     <= 1'b0;
      bus.ea_valid   <= 1'b0;
      bus.incr_out   <= '0;
      bus.incr_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
`ifdef EA_ALIGN_CHECK_EN
      bus.ea_misalign <= 1'b0;
`endif
    end else begin
      bus.ea_valid   <= 1'b0;
      bus.incr_valid <= 1'b0;
      bus.done       <= 1'b0;
`ifdef EA_ALIGN_CHECK_EN
      bus.ea_misalign <= 1'b0;
`endif
      // Dropping start outside IDLE aborts; it takes priority over any capture this edge.
      if (state != IDLE && !bus.start) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              sout_l   <= bus.Sout;
              dout_l   <= bus.Dout;
              as_l     <= bus.AdAs[1:0];
              ad_l     <= bus.AdAs[2];
              bw_l     <= bus.bw;
              bus.busy <= 1'b1;
              if (bus.AdAs[1:0] == 2'b01)      state <= SRC;
              else if (bus.AdAs[1:0] == 2'b11) state <= INC;
              else if (bus.AdAs[2])            state <= DST;
              else                             state <= FIN;
            end
          end
          SRC: begin
            if (bus.mdb_valid) begin
              bus.ea_out   <= src_sum;
              bus.ea_sel   <= 1'b0;
              bus.ea_valid <= 1'b1;
`ifdef EA_ALIGN_CHECK_EN
              bus.ea_misalign <= ~bw_l & src_sum[0];
`endif
              state <= ad_l ? DST : FIN;
            end
          end
          INC: begin
            bus.incr_out   <= inc_sum;
            bus.incr_valid <= 1'b1;
            state          <= ad_l ? DST : FIN;
          end
          DST: begin
            if (bus.mdb_valid) begin
              bus.ea_out   <= dst_sum;
              bus.ea_sel   <= 1'b1;
              bus.ea_valid <= 1'b1;
`ifdef EA_ALIGN_CHECK_EN
              bus.ea_misalign <= ~bw_l & dst_sum[0];
`endif
              state <= FIN;
            end
          end
          FIN: begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ea_calc.sv
// Scoreboard bench for ea_calc: driver pushes expected strobes, monitor pops and compares.
module tb_ea_calc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ea_calc_if #(.W(W)) bus ();

  ea_calc #(.W(W), .INC_BYTE(1), .INC_WORD(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // kind: 0 = ea strobe, 1 = incr strobe, 2 = done pulse
  typedef struct {
    int           kind;
    logic [W-1:0] val;
    logic         sel;
    logic         mis;
    int           cyc;
  } ev_t;

  typedef struct {
    logic         v;
    logic [W-1:0] w;
    int           kind;
    logic [W-1:0] val;
    logic         sel;
    logic         mis;
  } step_t;

  ev_t          q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cycle = 0;
  logic [W-1:0] exp_ea = '0;
  logic [W-1:0] exp_incr = '0;
  bit           mon_en = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: consumes one expected event for every strobe the DUT shows.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      while (q.size() > 0 && q[0].cyc < cycle) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_event: kind %0d expected at cycle %0d, not observed (now %0d)",
                 q[0].kind, q[0].cyc, cycle);
        void'(q.pop_front());
      end
      if (bus.ea_valid || bus.incr_valid || bus.done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_strobe: ea_valid=%0b incr_valid=%0b done=%0b expected none",
                   bus.ea_valid, bus.incr_valid, bus.done);
        end else begin
          ev_t ev;
          int  act_kind;
          ev = q.pop_front();
          act_kind = bus.ea_valid ? 0 : (bus.incr_valid ? 1 : 2);
          check("strobe_cycle", 64'(cycle), 64'(ev.cyc));
          check("strobe_kind", 64'(act_kind), 64'(ev.kind));
          check("strobe_onehot", 64'(int'(bus.ea_valid) + int'(bus.incr_valid) + int'(bus.done)), 64'd1);
          if (ev.kind == 0) begin
            check("ea_out", 64'(bus.ea_out), 64'(ev.val));
            check("ea_sel", 64'(bus.ea_sel), 64'(ev.sel));
`ifdef EA_ALIGN_CHECK_EN
            check("ea_misalign", 64'(bus.ea_misalign), 64'(ev.mis));
`endif
            exp_ea = ev.val;
          end else if (ev.kind == 1) begin
            check("incr_out", 64'(bus.incr_out), 64'(ev.val));
            exp_incr = ev.val;
          end
        end
      end
`ifdef EA_ALIGN_CHECK_EN
      if (!bus.ea_valid) check("ea_misalign_idle", 64'(bus.ea_misalign), 64'd0);
`endif
      check("ea_hold", 64'(bus.ea_out), 64'(exp_ea));
      check("incr_hold", 64'(bus.incr_out), 64'(exp_incr));
    end
  end

  function automatic step_t mk(input logic v, input logic [W-1:0] w, input int kind,
                               input logic [W-1:0] val, input logic sel, input logic mis);
    step_t s;
    s.v = v; s.w = w; s.kind = kind; s.val = val; s.sel = sel; s.mis = mis;
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ea_out"}, 64'(bus.ea_out), 64'd0);
    check({tag, "_ea_sel"}, 64'(bus.ea_sel), 64'd0);
    check({tag, "_ea_valid"}, 64'(bus.ea_valid), 64'd0);
    check({tag, "_incr_out"}, 64'(bus.incr_out), 64'd0);
    check({tag, "_incr_valid"}, 64'(bus.incr_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
`ifdef EA_ALIGN_CHECK_EN
    check({tag, "_ea_misalign"}, 64'(bus.ea_misalign), 64'd0);
`endif
  endtask

  // One instruction: the plan lists every clock edge after start is accepted,
  // with the extension-word timing and the result the instruction should produce.
  task automatic run_txn(input logic [2:0] adas, input logic bw_i,
                         input logic [W-1:0] s, input logic [W-1:0] d,
                         input logic [W-1:0] w1, input logic [W-1:0] w2,
                         input int gap1, input int gap2, input int abort_at);
    step_t        plan[$];
    logic [W-1:0] r;
    logic [1:0]   as_m;
    as_m = adas[1:0];
    if (as_m == 2'b01) begin
      repeat (gap1) plan.push_back(mk(1'b0, W'($urandom), -1, '0, 1'b0, 1'b0));
      r = s + w1;
      plan.push_back(mk(1'b1, w1, 0, r, 1'b0, !bw_i && r[0]));
    end else if (as_m == 2'b11) begin
      r = s + (bw_i ? W'(1) : W'(2));
      plan.push_back(mk(1'($urandom), W'($urandom), 1, r, 1'b0, 1'b0));
    end
    if (adas[2]) begin
      repeat (gap2) plan.push_back(mk(1'b0, W'($urandom), -1, '0, 1'b0, 1'b0));
      r = d + w2;
      plan.push_back(mk(1'b1, w2, 0, r, 1'b1, !bw_i && r[0]));
    end
    plan.push_back(mk(1'($urandom), W'($urandom), 2, '0, 1'b0, 1'b0));

    @(negedge clk);
    bus.start     = 1'b1;
    bus.AdAs      = adas;
    bus.bw        = bw_i;
    bus.Sout      = s;
    bus.Dout      = d;
    bus.mdb_valid = 1'($urandom);
    bus.MDB_out   = W'($urandom);
    @(negedge clk);
    for (int i = 0; i < plan.size(); i++) begin
      bus.AdAs = 3'($urandom);
      bus.bw   = 1'($urandom);
      bus.Sout = W'($urandom);
      bus.Dout = W'($urandom);
      check("busy_active", 64'(bus.busy), 64'd1);
      if (i == abort_at) begin
        bus.start     = 1'b0;
        bus.mdb_valid = 1'($urandom);
        bus.MDB_out   = W'($urandom);
        @(negedge clk);
        check("busy_after_abort", 64'(bus.busy), 64'd0);
        bus.mdb_valid = 1'b0;
        @(negedge clk);
        return;
      end
      bus.mdb_valid = plan[i].v;
      bus.MDB_out   = plan[i].w;
      if (plan[i].kind >= 0) begin
        ev_t ev;
        ev.kind = plan[i].kind;
        ev.val  = plan[i].val;
        ev.sel  = plan[i].sel;
        ev.mis  = plan[i].mis;
        ev.cyc  = cycle + 1;
        q.push_back(ev);
      end
      @(negedge clk);
    end
    bus.start     = 1'b0;
    bus.mdb_valid = 1'b0;
    check("busy_after_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.AdAs      = '0;
    bus.bw        = 1'b0;
    bus.Sout      = '0;
    bus.Dout      = '0;
    bus.MDB_out   = '0;
    bus.mdb_valid = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_txn(3'b001, 1'b0, 16'h0200, 16'h0000, 16'h0010, 16'h0000, 0, 0, -1);
    run_txn(3'b101, 1'b0, 16'h0100, 16'h0300, 16'h0004, 16'h0008, 1, 2, -1);
    run_txn(3'b111, 1'b1, 16'hFFFF, 16'h1000, 16'h0000, 16'h0002, 0, 1, -1);
    run_txn(3'b011, 1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 0, 0, -1);
    run_txn(3'b001, 1'b0, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 2, 0, -1);
    run_txn(3'b000, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 0, -1);
    run_txn(3'b010, 1'b1, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 0, -1);
    run_txn(3'b100, 1'b0, 16'h1234, 16'hFFFE, 16'h0000, 16'h0003, 0, 3, -1);
    run_txn(3'b001, 1'b0, 16'h0201, 16'h0000, 16'h0000, 16'h0000, 0, 0, -1);
    run_txn(3'b001, 1'b1, 16'h0201, 16'h0000, 16'h0000, 16'h0000, 0, 0, -1);
    // Abort while waiting in DST: source EA must stay on ea_out.
    run_txn(3'b101, 1'b0, 16'h0100, 16'h0300, 16'h0004, 16'h0008, 0, 3, 2);
    check("abort_holds_src_ea", 64'(bus.ea_out), 64'h0104);
    // Abort on the FIN edge: no done.
    run_txn(3'b000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

    // Reset while waiting in SRC clears everything.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.AdAs      = 3'b001;
    bus.Sout      = 16'h4444;
    bus.mdb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mdb_valid = 1'b1;
    @(negedge clk);
    check_all_zero("mid_src_reset");
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.mdb_valid = 1'b0;
    exp_ea        = '0;
    exp_incr      = '0;
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] adas;
      int         plen;
      int         ab;
      adas = 3'($urandom);
      plen = (adas[1:0] == 2'b01 || adas[1:0] == 2'b11 ? 1 : 0) + (adas[2] ? 1 : 0) + 1;
      ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, plen - 1)) : -1;
      run_txn(adas, 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab);
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d events left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
